fft_r2_sdf_stage: RTL and testbench

// - Parametrised radix-2 DIF butterfly stage for the parallel-lane streaming FFT: LANES complex samples/cycle.
// - Pairs input block k with block k+DELAY via an internal delay line.
// - Emits sums immediately; stores differences and emits them in the next phase, self-draining after the last frame.
// - Generalises the fixed 16-lane, fixed-depth stage: configurable width, lanes and depth; frame/error tracking.

---
 rtl/fft_r2_sdf_stage_pkg.sv | 22 ++
 rtl/fft_r2_sdf_stage_if.sv | 17 +
 rtl/fft_r2_sdf_stage_delay_line.sv | 33 +++
 rtl/fft_r2_sdf_stage.sv | 101 ++++++++++
 tb/tb_fft_r2_sdf_stage.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/fft_r2_sdf_stage_pkg.sv
// fft_pkg: shared state type and arithmetic helpers for the radix-2 SDF stage.
// FFT_STAGE_SCALE_EN selects the scaled (IN_W) output width.
package fft_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_BFLY, ST_DRAIN} stage_state_e;

   function automatic int out_w(input int w);
`ifdef FFT_STAGE_SCALE_EN
      return w;
`else
      return w + 1;
`endif
   endfunction

   // Round half up by one bit, then clamp into a signed w-bit range.
   function automatic logic signed [31:0] sat_round_half(input logic signed [31:0] x, input int w);
      logic signed [31:0] r, hi, lo;
      r  = (x + 32'sd1) >>> 1;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      return r > hi ? hi : r < lo ? lo : r;
   endfunction
endpackage

// File: rtl/fft_r2_sdf_stage_if.sv
// fft_r2_sdf_stage_if: lane-parallel complex sample stream into and out of the SDF stage.
// FFT_STAGE_SCALE_EN (via fft_pkg::out_w) sets the default output width.
interface fft_r2_sdf_stage_if
   import fft_pkg::*;
#(
   parameter int IN_W  = 12,
   parameter int LANES = 16,
   parameter int OUT_W = out_w(IN_W)
);
   logic                             din_valid;
   logic [LANES-1:0][IN_W-1:0]       din_re, din_im;
   logic                             dout_valid, dout_sof;
   logic [LANES-1:0][OUT_W-1:0]      dout_re, dout_im;

   modport master (output din_valid, din_re, din_im, input dout_valid, dout_sof, dout_re, dout_im);
   modport slave  (input din_valid, din_re, din_im, output dout_valid, dout_sof, dout_re, dout_im);
endinterface

// File: rtl/fft_r2_sdf_stage_delay_line.sv
// fft_delay_line: DELAY-deep, LANES-wide complex shift register; each enabled cycle pushes one
// block at the tail and advances the oldest block to the head.
module fft_delay_line #(
   parameter int W     = 13,
   parameter int LANES = 16,
   parameter int DELAY = 2
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    en,
   input  logic [LANES-1:0][W-1:0] push_re,
   input  logic [LANES-1:0][W-1:0] push_im,
   output logic [LANES-1:0][W-1:0] head_re,
   output logic [LANES-1:0][W-1:0] head_im
);
   logic [DELAY-1:0][LANES-1:0][W-1:0] sr_re, sr_im;

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         sr_re <= '0;
         sr_im <= '0;
      end else if (en) begin
         for (int k = DELAY - 1; k > 0; k--) begin
            sr_re[k] <= sr_re[k-1];
            sr_im[k] <= sr_im[k-1];
         end
         sr_re[0] <= push_re;
         sr_im[0] <= push_im;
      end

   assign head_re = sr_re[DELAY-1];
   assign head_im = sr_im[DELAY-1];
endmodule

// File: rtl/fft_r2_sdf_stage.sv
// fft_r2_sdf_stage: radix-2 DIF single-delay-feedback butterfly stage, LANES complex samples/cycle.
// FFT_STAGE_SCALE_EN: outputs are rounded half-up, halved and saturated back to IN_W bits.
module fft_r2_sdf_stage
   import fft_pkg::*;
#(
   parameter int IN_W  = 12,
   parameter int LANES = 16,
   parameter int DELAY = 2
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               err_clr,
   output logic               err_gap,
   fft_r2_sdf_stage_if.slave  bus
);
   localparam int OUT_W = out_w(IN_W);
   localparam int SW    = IN_W + 1;
   localparam int CW    = DELAY > 1 ? $clog2(DELAY) : 1;

   stage_state_e            st, st_n;
   logic [CW-1:0]           cnt, cnt_n;
   logic                    pend, pend_n;
   logic                    last, start, fill_ph, bfly_ph, drain_ph, act, gap, err_set, ov;
   logic [LANES-1:0][SW-1:0]    push_re, push_im, head_re, head_im;
   logic [LANES-1:0][OUT_W-1:0] res_re, res_im;

   // A cycle after the last BFLY (DRAIN, count 0) with valid input starts a back-to-back frame.
   assign last     = cnt == CW'(DELAY - 1);
   assign start    = bus.din_valid && (st == ST_IDLE || (st == ST_DRAIN && cnt == '0));
   assign fill_ph  = start || (st == ST_FILL && bus.din_valid);
   assign bfly_ph  = st == ST_BFLY && bus.din_valid;
   assign drain_ph = st == ST_DRAIN && !start;
   assign act      = fill_ph || bfly_ph || drain_ph;
   assign gap      = (st == ST_FILL || st == ST_BFLY) && !bus.din_valid;
   assign err_set  = gap || (drain_ph && bus.din_valid);
   assign ov       = bfly_ph || drain_ph || (fill_ph && pend);

   always_comb begin
      st_n   = gap ? ST_IDLE : !act ? st
             : fill_ph ? (last ? ST_BFLY : ST_FILL)
             : bfly_ph ? (last ? ST_DRAIN : ST_BFLY)
             : (last ? ST_IDLE : ST_DRAIN);
      cnt_n  = (gap || (act && last)) ? '0 : act ? cnt + 1'b1 : cnt;
      pend_n = gap ? 1'b0 : !act ? pend : bfly_ph ? last : pend && !last;
   end

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         st   <= ST_IDLE;
         cnt  <= '0;
         pend <= 1'b0;
      end else begin
         st   <= st_n;
         cnt  <= cnt_n;
         pend <= pend_n;
      end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic signed [SW-1:0] a_re, a_im, b_re, b_im, o_re, o_im;
      assign a_re = $signed(head_re[i]);
      assign a_im = $signed(head_im[i]);
      assign b_re = SW'($signed(bus.din_re[i]));
      assign b_im = SW'($signed(bus.din_im[i]));
      assign push_re[i] = bfly_ph ? a_re - b_re : fill_ph ? b_re : '0;
      assign push_im[i] = bfly_ph ? a_im - b_im : fill_ph ? b_im : '0;
      assign o_re = bfly_ph ? a_re + b_re : a_re;
      assign o_im = bfly_ph ? a_im + b_im : a_im;
`ifdef FFT_STAGE_SCALE_EN
      assign res_re[i] = OUT_W'(sat_round_half(32'(o_re), IN_W));
      assign res_im[i] = OUT_W'(sat_round_half(32'(o_im), IN_W));
`else
      assign res_re[i] = o_re;
      assign res_im[i] = o_im;
`endif
   end

   fft_delay_line #(.W(SW), .LANES(LANES), .DELAY(DELAY)) u_dl (
      .clk     (clk),
      .rstn    (rstn),
      .en      (act),
      .push_re (push_re),
      .push_im (push_im),
      .head_re (head_re),
      .head_im (head_im)
   );

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         bus.dout_valid <= 1'b0;
         bus.dout_sof   <= 1'b0;
         bus.dout_re    <= '0;
         bus.dout_im    <= '0;
         err_gap        <= 1'b0;
      end else begin
         bus.dout_valid <= ov;
         bus.dout_sof   <= bfly_ph && cnt == '0;
         bus.dout_re    <= ov ? res_re : '0;
         bus.dout_im    <= ov ? res_im : '0;
         err_gap        <= err_set || (err_gap && !err_clr);
      end
endmodule

// File: tb/tb_fft_r2_sdf_stage.sv
// tb_fft_r2_sdf_stage: directed checks of the radix-2 SDF stage (IN_W=12, LANES=16, DELAY=2).
// Expected outputs follow FFT_STAGE_SCALE_EN when it is defined.
module tb_fft_r2_sdf_stage;
   import fft_pkg::*;
   localparam int IN_W  = 12;
   localparam int LANES = 16;
   localparam int OUT_W = out_w(IN_W);

   logic clk, rstn, err_clr, err_gap;
   int   n_chk = 0, n_err = 0;

   fft_r2_sdf_stage_if #(.IN_W(IN_W), .LANES(LANES), .OUT_W(OUT_W)) bus ();

   fft_r2_sdf_stage #(.IN_W(IN_W), .LANES(LANES), .DELAY(2)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .err_clr (err_clr),
      .err_gap (err_gap),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int scl(input int x);
`ifdef FFT_STAGE_SCALE_EN
      int r;
      r = (x + 1) >>> 1;
      return r > 2047 ? 2047 : r < -2048 ? -2048 : r;
`else
      return x;
`endif
   endfunction

   // Lane-0 value when all lanes agree, otherwise a marker no test expects.
   function automatic int lanes(input bit use_im);
      int v, x;
      v = use_im ? int'($signed(bus.dout_im[0])) : int'($signed(bus.dout_re[0]));
      for (int l = 1; l < LANES; l++) begin
         x = use_im ? int'($signed(bus.dout_im[l])) : int'($signed(bus.dout_re[l]));
         if (x != v) return 'h5a5a5a5a;
      end
      return v;
   endfunction

   task automatic cyc(input logic v, input int re, input int im);
      bus.din_valid = v;
      for (int l = 0; l < LANES; l++) begin
         bus.din_re[l] = IN_W'(re);
         bus.din_im[l] = IN_W'(im);
      end
      @(negedge clk);
   endtask

   task automatic exp_out(input string tag, input logic v, input logic s, input int re, input int im);
      chk({tag, ".valid"}, int'(bus.dout_valid), int'(v));
      chk({tag, ".sof"}, int'(bus.dout_sof), int'(s));
      if (v) begin
         chk({tag, ".re"}, lanes(1'b0), scl(re));
         chk({tag, ".im"}, lanes(1'b1), scl(im));
      end
   endtask

   task automatic frame1(input string tag);
      cyc(1, 100, 0); exp_out({tag, ".t1"}, 0, 0, 0, 0);
      cyc(1, 200, 0); exp_out({tag, ".t2"}, 0, 0, 0, 0);
      cyc(1, 300, 0); exp_out({tag, ".t3"}, 1, 1, 400, 0);
      cyc(1, 400, 0); exp_out({tag, ".t4"}, 1, 0, 600, 0);
      cyc(0, 0, 0);   exp_out({tag, ".t5"}, 1, 0, -200, 0);
      cyc(0, 0, 0);   exp_out({tag, ".t6"}, 1, 0, -200, 0);
      cyc(0, 0, 0);   exp_out({tag, ".t7"}, 0, 0, 0, 0);
      cyc(0, 0, 0);   exp_out({tag, ".t8"}, 0, 0, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0;
      err_clr = 1'b0;
      bus.din_valid = 1'b0;
      bus.din_re = '0;
      bus.din_im = '0;
      repeat (2) @(negedge clk);
      chk("rst.valid", int'(bus.dout_valid), 0);
      chk("rst.sof", int'(bus.dout_sof), 0);
      chk("rst.re", lanes(1'b0), 0);
      chk("rst.err", int'(err_gap), 0);
      rstn = 1'b1;
      @(negedge clk);

      frame1("single");

      cyc(1, 100, 0);  exp_out("b2b.t1", 0, 0, 0, 0);
      cyc(1, 200, 0);  exp_out("b2b.t2", 0, 0, 0, 0);
      cyc(1, 300, 0);  exp_out("b2b.t3", 1, 1, 400, 0);
      cyc(1, 400, 0);  exp_out("b2b.t4", 1, 0, 600, 0);
      cyc(1, 10, -10); exp_out("b2b.t5", 1, 0, -200, 0);
      cyc(1, 20, -20); exp_out("b2b.t6", 1, 0, -200, 0);
      cyc(1, 30, -30); exp_out("b2b.t7", 1, 1, 40, -40);
      cyc(1, 40, -40); exp_out("b2b.t8", 1, 0, 60, -60);
      cyc(0, 0, 0);    exp_out("b2b.t9", 1, 0, -20, 20);
      cyc(0, 0, 0);    exp_out("b2b.t10", 1, 0, -20, 20);
      cyc(0, 0, 0);    exp_out("b2b.t11", 0, 0, 0, 0);
      chk("b2b.err", int'(err_gap), 0);

      cyc(1, -2048, 0); exp_out("ext.t1", 0, 0, 0, 0);
      cyc(1, 2047, 0);  exp_out("ext.t2", 0, 0, 0, 0);
      cyc(1, -2048, 0); exp_out("ext.t3", 1, 1, -4096, 0);
      cyc(1, -2048, 0); exp_out("ext.t4", 1, 0, -1, 0);
      cyc(0, 0, 0);     exp_out("ext.t5", 1, 0, 0, 0);
      cyc(0, 0, 0);     exp_out("ext.t6", 1, 0, 4095, 0);
      cyc(0, 0, 0);     exp_out("ext.t7", 0, 0, 0, 0);

      cyc(1, 100, 0); chk("gap.t1.err", int'(err_gap), 0);
      cyc(0, 0, 0);   chk("gap.t2.err", int'(err_gap), 1);
      exp_out("gap.t2", 0, 0, 0, 0);
      cyc(0, 0, 0);   exp_out("gap.t3", 0, 0, 0, 0);
      cyc(0, 0, 0);   exp_out("gap.t4", 0, 0, 0, 0);
      cyc(0, 0, 0);   exp_out("gap.t5", 0, 0, 0, 0);
      err_clr = 1'b1;
      cyc(0, 0, 0);   chk("clr.err", int'(err_gap), 0);
      err_clr = 1'b0;
      cyc(1, 100, 0); chk("clrwin.t1.err", int'(err_gap), 0);
      err_clr = 1'b1;
      cyc(0, 0, 0);   chk("clrwin.t2.err", int'(err_gap), 1);
      cyc(0, 0, 0);   chk("clrwin.t3.err", int'(err_gap), 0);
      err_clr = 1'b0;
      cyc(0, 0, 0);

      cyc(1, 100, 0); exp_out("drn.t1", 0, 0, 0, 0);
      cyc(1, 200, 0); exp_out("drn.t2", 0, 0, 0, 0);
      cyc(1, 300, 0); exp_out("drn.t3", 1, 1, 400, 0);
      cyc(1, 400, 0); exp_out("drn.t4", 1, 0, 600, 0);
      cyc(0, 0, 0);   exp_out("drn.t5", 1, 0, -200, 0);
      chk("drn.t5.err", int'(err_gap), 0);
      cyc(1, 999, 0); exp_out("drn.t6", 1, 0, -200, 0);
      chk("drn.t6.err", int'(err_gap), 1);
      cyc(0, 0, 0);   exp_out("drn.t7", 0, 0, 0, 0);
      cyc(0, 0, 0);   exp_out("drn.t8", 0, 0, 0, 0);

      cyc(1, 100, 0);
      cyc(1, 200, 0);
      cyc(1, 300, 0);
      cyc(1, 400, 0);
      cyc(0, 0, 0);   exp_out("rst2.t5", 1, 0, -200, 0);
      rstn = 1'b0;
      #1;
      chk("rst2.valid", int'(bus.dout_valid), 0);
      chk("rst2.re", lanes(1'b0), 0);
      chk("rst2.err", int'(err_gap), 0);
      @(negedge clk);
      rstn = 1'b1;
      cyc(0, 0, 0);   exp_out("rst2.idle", 0, 0, 0, 0);
      frame1("fresh");
      chk("fresh.err", int'(err_gap), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
